// File: rtl/mff_fetch_ir.sv
// Show-ahead fifo reader and interpolation-rate phase counter for the clk_w domain.
// Optional `HOLD_ON_UNDERFLOW_EN: keep the previous I/Q on underflow instead of zeroing them.
module mff_fetch_ir #(
   parameter int unsigned DW     = 16,
   parameter int unsigned MAX_IR = 5,
   parameter int unsigned UCW    = 16
) (
   input  logic           clk,
   input  logic           rstin,
   input  logic [2:0]     ir,
   input  logic           bitsize,
   input  logic [DW-1:0]  fifo_in,
   input  logic           dav,
   output logic           rdreq,
   output logic [7:0]     state,
   output logic [DW-1:0]  i_out,
   output logic [DW-1:0]  q_out,
   output logic           sample_strb,
   output logic           underflow,
   input  logic           uf_clr,
   output logic [UCW-1:0] uf_count
);

   localparam int unsigned H        = DW / 2;
   localparam logic [2:0]  MAX_IR_W = 3'(MAX_IR);

   typedef enum logic [1:0] {F_I, F_Q, HAVE} fetch_t;

   fetch_t        fsm, nxt_fsm;
   logic [DW-1:0] i_lat, q_lat, nxt_i, nxt_q;
   logic [2:0]    ir_eff;
   logic [7:0]    mask;
   logic          pend, complete;

   assign ir_eff = (ir > MAX_IR_W) ? 3'd0 : ir;
   assign mask   = 8'((9'd8 << ir_eff) - 9'd1);
   assign pend   = (state == mask);
   assign rdreq  = rstin && dav && ((fsm == F_I) || (fsm == F_Q));

   // A read that completes the sample on the period-end cycle is forwarded straight to the outputs.
   always_comb begin
      nxt_i   = i_lat;
      nxt_q   = q_lat;
      nxt_fsm = fsm;
      case (fsm)
         F_I: if (rdreq) begin
            if (bitsize) begin
               nxt_i   = {fifo_in[DW-1:H], {H{1'b0}}};
               nxt_q   = {fifo_in[H-1:0], {H{1'b0}}};
               nxt_fsm = HAVE;
            end else begin
               nxt_i   = fifo_in;
               nxt_fsm = F_Q;
            end
         end
         F_Q: if (rdreq) begin
            nxt_q   = fifo_in;
            nxt_fsm = HAVE;
         end
         default: ;
      endcase
   end

   assign complete = (nxt_fsm == HAVE);

   always_ff @(posedge clk or negedge rstin) begin
      if (!rstin) begin
         state       <= '0;
         i_out       <= '0;
         q_out       <= '0;
         sample_strb <= 1'b0;
         underflow   <= 1'b0;
         uf_count    <= '0;
         i_lat       <= '0;
         q_lat       <= '0;
         fsm         <= F_I;
      end else begin
         state       <= (state + 8'd1) & mask;
         sample_strb <= 1'b0;
         underflow   <= 1'b0;
         i_lat       <= nxt_i;
         q_lat       <= nxt_q;
         if (pend && complete) begin
            i_out       <= nxt_i;
            q_out       <= nxt_q;
            sample_strb <= 1'b1;
            fsm         <= F_I;
         end else if (pend) begin
            underflow <= 1'b1;
`ifdef HOLD_ON_UNDERFLOW_EN
`else
            i_out     <= '0;
            q_out     <= '0;
`endif
            // An F_Q underflow stays in F_Q so the I/Q word pairing survives the boundary.
            fsm       <= nxt_fsm;
         end else begin
            fsm <= nxt_fsm;
         end
         if (uf_clr)
            uf_count <= '0;
         else if (pend && !complete && (uf_count != '1))
            uf_count <= uf_count + UCW'(1);
      end
   end

endmodule

// File: tb/tb_mff_fetch_ir.sv
// Self-checking bench for mff_fetch_ir: vector table plus hand sequences, with an
// event scoreboard fed by the stimulus and drained by a strb/underflow monitor.
module tb_mff_fetch_ir;

   logic        clk = 1'b0;
   logic        rstin = 1'b0;
   logic [2:0]  ir = 3'd0;
   logic        bitsize = 1'b0;
   logic [15:0] fifo_in;
   logic        dav;
   logic        rdreq;
   logic [7:0]  state;
   logic [15:0] i_out, q_out;
   logic        sample_strb, underflow;
   logic        uf_clr = 1'b0;
   logic [15:0] uf_count;

   logic        rdreq2, strb2, uf2_pulse;
   logic [7:0]  state2;
   logic [15:0] i2, q2;
   logic [1:0]  uf2;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mff_fetch_ir #(.DW(16), .MAX_IR(5), .UCW(16)) dut (
      .clk(clk), .rstin(rstin), .ir(ir), .bitsize(bitsize), .fifo_in(fifo_in), .dav(dav),
      .rdreq(rdreq), .state(state), .i_out(i_out), .q_out(q_out), .sample_strb(sample_strb),
      .underflow(underflow), .uf_clr(uf_clr), .uf_count(uf_count));

   // Permanently starved narrow-counter instance for the saturation check.
   mff_fetch_ir #(.DW(16), .MAX_IR(5), .UCW(2)) dut2 (
      .clk(clk), .rstin(rstin), .ir(ir), .bitsize(bitsize), .fifo_in(16'h0000), .dav(1'b0),
      .rdreq(rdreq2), .state(state2), .i_out(i2), .q_out(q2), .sample_strb(strb2),
      .underflow(uf2_pulse), .uf_clr(1'b0), .uf_count(uf2));

   // Show-ahead fifo model.
   logic [15:0] mem [256];
   logic [7:0]  rd_ptr = 8'd0;
   logic [7:0]  wr_ptr = 8'd0;
   assign fifo_in = mem[rd_ptr];
   assign dav     = (rd_ptr != wr_ptr);
   always @(posedge clk) if (rstin && rdreq) rd_ptr <= rd_ptr + 8'd1;

   typedef struct packed {
      logic        uf;
      logic [15:0] i;
      logic [15:0] q;
   } ev_t;
   ev_t exp_q[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s actual=%h required=%h @%0t", nm, act, req, $time);
      end
   endtask

   logic [15:0] last_i = 16'h0, last_q = 16'h0;
   always @(negedge clk) begin
      if (!rstin) begin
         last_i = 16'h0;
         last_q = 16'h0;
      end else if (sample_strb || underflow) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_event actual=strb%0d/uf%0d required=none @%0t",
                     sample_strb, underflow, $time);
         end else begin
            ev_t e;
            e = exp_q.pop_front();
            chk("ev_kind", 32'({sample_strb, underflow}), e.uf ? 32'h1 : 32'h2);
            if (e.uf) begin
`ifdef HOLD_ON_UNDERFLOW_EN
               chk("uf_i", 32'(i_out), 32'(last_i));
               chk("uf_q", 32'(q_out), 32'(last_q));
`else
               chk("uf_i", 32'(i_out), 32'h0);
               chk("uf_q", 32'(q_out), 32'h0);
`endif
            end else begin
               chk("strb_i", 32'(i_out), 32'(e.i));
               chk("strb_q", 32'(q_out), 32'(e.q));
            end
         end
         if (sample_strb) begin
            last_i = i_out;
            last_q = q_out;
         end
      end
   end

   task automatic tick(input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic push(input logic [15:0] w);
      mem[wr_ptr] = w;
      wr_ptr = wr_ptr + 8'd1;
   endtask

   task automatic exp_strb(input logic [15:0] i, input logic [15:0] q);
      exp_q.push_back({1'b0, i, q});
   endtask

   task automatic exp_uf();
      exp_q.push_back({1'b1, 16'h0, 16'h0});
   endtask

   task automatic do_reset();
      rstin  = 1'b0;
      uf_clr = 1'b0;
      tick(2);
      exp_q.delete();
      wr_ptr = rd_ptr;
   endtask

   task automatic release_rst();
      rstin = 1'b1;
      #1;
   endtask

   typedef struct {
      logic [2:0]  ir;
      logic        bs;
      logic [15:0] w0, w1;
      int          nw;
      logic [15:0] ei, eq;
   } vec_t;
   vec_t vecs[7];

   initial begin
      logic [7:0] p0;
      int         nper;

      vecs[0] = '{3'd0, 1'b0, 16'h1234, 16'h5678, 2, 16'h1234, 16'h5678};
      vecs[1] = '{3'd2, 1'b1, 16'h80FF, 16'h0000, 1, 16'h8000, 16'hFF00};
      vecs[2] = '{3'd1, 1'b0, 16'hAAAA, 16'h5555, 2, 16'hAAAA, 16'h5555};
      vecs[3] = '{3'd5, 1'b1, 16'h1234, 16'h0000, 1, 16'h1200, 16'h3400};
      vecs[4] = '{3'd7, 1'b0, 16'hDEAD, 16'hBEEF, 2, 16'hDEAD, 16'hBEEF};
      vecs[5] = '{3'd3, 1'b1, 16'hFFFF, 16'h0000, 1, 16'hFF00, 16'hFF00};
      vecs[6] = '{3'd4, 1'b0, 16'h0001, 16'h8000, 2, 16'h0001, 16'h8000};

      tick(1);
      chk("rst_state", 32'(state), 32'h0);
      chk("rst_iq", 32'({i_out, q_out}), 32'h0);
      chk("rst_flags", 32'({sample_strb, underflow, rdreq}), 32'h0);
      chk("rst_ufc", 32'(uf_count), 32'h0);

      // Single-sample vectors, one period each.
      foreach (vecs[v]) begin
         do_reset();
         ir      = vecs[v].ir;
         bitsize = vecs[v].bs;
         nper    = (vecs[v].ir > 3'd5) ? 8 : (8 << vecs[v].ir);
         push(vecs[v].w0);
         if (vecs[v].nw == 2) push(vecs[v].w1);
         exp_strb(vecs[v].ei, vecs[v].eq);
         p0 = rd_ptr;
         release_rst();
         chk("v_state0", 32'(state), 32'h0);
         chk("v_rdreq0", 32'(rdreq), 32'h1);
         tick(1);
         chk("v_rdreq1", 32'(rdreq), vecs[v].bs ? 32'h0 : 32'h1);
         tick(nper - 1);
         chk("v_drained", 32'(exp_q.size()), 32'h0);
         chk("v_reads", 32'(8'(rd_ptr - p0)), 32'(vecs[v].nw));
         chk("v_ufc", 32'(uf_count), 32'h0);
         chk("v_i", 32'(i_out), 32'(vecs[v].ei));
         chk("v_q", 32'(q_out), 32'(vecs[v].eq));
      end

      // Underflow while waiting for the Q word, then completion in the next period.
      do_reset();
      ir = 3'd0; bitsize = 1'b0;
      push(16'h1111);
      exp_uf();
      release_rst();
      tick(8);
      chk("fq_ufc", 32'(uf_count), 32'h1);
      chk("fq_drained", 32'(exp_q.size()), 32'h0);
      bitsize = 1'b1;
      push(16'h2222);
      exp_strb(16'h1111, 16'h2222);
      tick(8);
      chk("fq_pair_done", 32'(exp_q.size()), 32'h0);
      chk("fq_ufc2", 32'(uf_count), 32'h1);

      // Starved counting, clear colliding with an underflow, saturation on UCW=2.
      do_reset();
      ir = 3'd0; bitsize = 1'b0;
      release_rst();
      for (int p = 1; p <= 3; p++) begin
         exp_uf();
         tick(8);
         chk("ufc_count", 32'(uf_count), 32'(p));
      end
      exp_uf();
      tick(7);
      chk("ufc_state7", 32'(state), 32'h7);
      uf_clr = 1'b1;
      tick(1);
      uf_clr = 1'b0;
      chk("ufc_clr", 32'(uf_count), 32'h0);
      chk("ufc_drained", 32'(exp_q.size()), 32'h0);
      exp_uf();
      tick(8);
      chk("ufc_after_clr", 32'(uf_count), 32'h1);
      chk("ufc_sat", 32'(uf2), 32'h3);

      // Asynchronous reset while in F_Q; restart must begin in F_I at state 0.
      do_reset();
      ir = 3'd0; bitsize = 1'b0;
      push(16'hA1A1); push(16'hB2B2); push(16'hC3C3);
      exp_strb(16'hA1A1, 16'hB2B2);
      release_rst();
      tick(10);
      chk("ar_pre_state", 32'(state), 32'h2);
      chk("ar_pre_rdreq", 32'(rdreq), 32'h0);
      chk("ar_pre_i", 32'(i_out), 32'hA1A1);
      #2;
      bitsize = 1'b1;
      push(16'hABCD);
      rstin = 1'b0;
      #1;
      chk("ar_state", 32'(state), 32'h0);
      chk("ar_iq", 32'({i_out, q_out}), 32'h0);
      chk("ar_rdreq", 32'(rdreq), 32'h0);
      tick(2);
      exp_q.delete();
      exp_strb(16'hAB00, 16'hCD00);
      release_rst();
      chk("ar_rel_state", 32'(state), 32'h0);
      tick(1);
      chk("ar_rel_state1", 32'(state), 32'h1);
      tick(7);
      chk("ar_fi_sample", 32'(exp_q.size()), 32'h0);

      // ir change 3 -> 1 at state 20 truncates the period without a spurious strb.
      do_reset();
      ir = 3'd3; bitsize = 1'b1;
      push(16'h1234);
      exp_strb(16'h1200, 16'h3400);
      release_rst();
      tick(20);
      chk("irs_state20", 32'(state), 32'd20);
      ir = 3'd1;
      tick(1);
      chk("irs_wrap", 32'(state), 32'd5);
      tick(10);
      chk("irs_state15", 32'(state), 32'd15);
      chk("irs_pending", 32'(exp_q.size()), 32'h1);
      tick(1);
      chk("irs_strb", 32'(exp_q.size()), 32'h0);
      chk("irs_state0", 32'(state), 32'h0);

      rstin = 1'b0;
      tick(1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mff_fetch_ir.md
Name: mff_fetch_ir

Overview:
- Parametrised successor to the memory-fifo reader and interpolation-rate state counter.
- Owns the per-sample phase counter, which has a modulus set by the interpolation code.
- Pulls 16-bit-pair or 8-bit-packed I/Q words from the show-ahead memory fifo.
- Delivers one aligned I/Q sample per period to the interpolator, with defined underflow handling and an underflow counter.
- Sits between the memory fifo read port and the interpolator/DAC path, in the clk_w domain.

Parameters:
- DW, 16, sample and fifo word width; even, at least 8.
- MAX_IR, 5, largest legal interpolation code; codes above it are treated as 0.
- UCW, 16, underflow counter width.

Ports:
- clk  input  1  sample-domain clock (clk_w)
- rstin  input  1  reset, asynchronous, active-low
- ir  input  3  interpolation code; period N = 8<<ir (code 0 = x2, N=8 … code 5 = x64, N=256)
- bitsize  input  1  word format:
  - 0 = two words per sample, I then Q
  - 1 = one word per sample, I in [DW-1:DW/2], Q in [DW/2-1:0]
- fifo_in  input  DW  show-ahead fifo output word
- dav  input  1  fifo not empty
- rdreq  output  1  fifo read acknowledge; word on fifo_in is consumed this cycle
- state  output  8  phase counter, 0..N-1
- i_out  output  DW  I sample to interpolator
- q_out  output  DW  Q sample to interpolator
- sample_strb  output  1  one-cycle pulse when i_out/q_out update
- underflow  output  1  one-cycle pulse at a period end with no complete sample
- uf_clr  input  1  synchronous clear of uf_count
- uf_count  output  UCW  saturating underflow count

Behaviour:
- Reset (rstin=0, asynchronous): state, i_out, q_out, sample_strb, underflow, rdreq and uf_count are all 0; fetch FSM is in F_I; internal latches are 0.
- Phase counter:
  - state <= (state+1) & (N-1) every cycle.
  - An ir change applies from the next cycle, and the current value is masked by the new modulus.
- rdreq is combinational: asserted only when dav=1 and the FSM is in a reading state (rules below). It is never asserted with dav=0.
- Fetch FSM states: F_I, F_Q, HAVE.
  - F_I: rdreq=dav.
    - On a read with bitsize=1: I latch = {fifo_in[DW-1:DW/2], DW/2 zeros}, Q latch = {fifo_in[DW/2-1:0], DW/2 zeros}, go to HAVE.
    - On a read with bitsize=0: I latch = fifo_in, go to F_Q.
  - F_Q: rdreq=dav. On a read, Q latch = fifo_in, go to HAVE.
  - HAVE: rdreq=0; wait.
- Period end (state==N-1):
  - If the FSM is in HAVE: the latches load i_out/q_out on the next edge, sample_strb=1 for that cycle, and the FSM goes to F_I.
  - Otherwise it is an underflow: underflow=1, uf_count increments (saturating at all ones), and i_out/q_out load 0.
    - In F_I the FSM stays in F_I.
    - In F_Q the FSM stays in F_Q, so the pending Q word is awaited across the boundary and I/Q word pairing is never broken.
  - A read that completes the sample on the period-end cycle itself counts as HAVE for that boundary: its latch value is forwarded, and it is not an underflow.
- Output latency: a sample fetched in period k appears at the end of period k. The output update and the strb/underflow pulse occur together on the clock edge after state==N-1.
- Fetching starts immediately after the boundary, i.e. at state 0.
- uf_clr has priority over a simultaneous increment; the count goes to 0.
- bitsize is sampled only at the F_I read. A change while in F_Q completes the current pair in the old format.
- Changing ir mid-period truncates or extends the period. There is no spurious strb: a strb requires state==N-1 under the current N.

Optional Feature:
- Macro HOLD_ON_UNDERFLOW_EN.
- Defined: on underflow, i_out/q_out hold their previous values; underflow and uf_count behave as normal.
- Undefined: on underflow, i_out/q_out are driven to 0 (carrier-off behaviour).

Test Plan:
- ir=0, bitsize=0, fifo preloaded with 0x1234, 0x5678:
  - rdreq pulses at state 0 and state 1.
  - After state 7, i_out=0x1234, q_out=0x5678, sample_strb for 1 cycle, uf_count=0.
- ir=2 (N=32), bitsize=1, word 0x80FF:
  - A single rdreq occurs.
  - i_out=0x8000, q_out=0xFF00 at end of period.
- bitsize=0, only 0x1111 available (dav drops after one read), ir=0:
  - underflow at the first period end; outputs are 0 (or held with the macro); FSM stays in F_Q.
  - Push 0x2222 in the next period: the next strb gives i=0x1111, q=0x2222.
- Empty fifo for 3 periods, then uf_clr pulsed in the same cycle as a 4th underflow:
  - uf_count goes 1, 2, 3, then 0.
  - With UCW=2, a long starve saturates the count at 3.
- Assert rstin low mid-period while in F_Q:
  - All outputs go to 0 asynchronously and the FSM returns to F_I.
  - After release, state counts from 0.
- Switch ir from 3 to 1 while state=20:
  - The next state is (21 & 15) = 5.
  - The strb arrives at the following state==15; no strb occurs at 31.
